// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared types and field constants for the ps2_key producer
package ps2_key_pkg;

  localparam int KEY_W       = 11;
  localparam int TOGGLE_BIT  = 10;
  localparam int PRESSED_BIT = 9;
  localparam int EXT_BIT     = 8;

  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  // What sits in the queue: everything except the toggle, which is owned by the emitter.
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HOLDOFF     = 2'd1,
    ST_REPEAT_WAIT = 2'd2
  } tx_state_t;

  function automatic ps2_key_t next_key(input ps2_key_t cur, input ps2_event_t ev);
    return {~cur.toggle, ev};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - synchronous event queue with registered occupancy count
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  ps2_event_t             i_data,
  input  logic                   i_pop,
  output ps2_event_t             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  ps2_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ps2_key_tx.sv
// rtl/ps2_key_tx.sv - queued ps2_key event producer with spaced toggle updates
// Typematic repeat of the last press is built only when PS2_TX_REPEAT_EN is defined.
module ps2_key_tx
  import ps2_key_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int GAP_CYCLES   = 4,
  parameter int REPEAT_DELAY = 24000000,
  parameter int REPEAT_RATE  = 2400000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_code,
  input  logic             in_ext,
  input  logic             in_pressed,
  output logic [KEY_W-1:0] ps2_key,
  output logic             busy
);

  localparam int HW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(GAP_CYCLES - 1);

  ps2_key_t              r_key;
  logic [HW-1:0]         r_holdoff;
  tx_state_t             r_state;
  tx_state_t             w_rest_emit;
  tx_state_t             w_rest_hold;
  ps2_event_t            w_in_event;
  ps2_event_t            w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_push;
  logic                  w_emit;

  assign w_in_event = {in_pressed, in_ext, in_code};
  assign in_ready   = !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_emit     = !w_empty && (r_holdoff == '0);
  assign ps2_key    = r_key;
  // HOLDOFF covers both a running gap and the one cycle before a queued re-emit.
  assign busy       = (w_count != '0) || (r_state == ST_HOLDOFF);

  ps2_key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in_event),
    .i_pop   (w_emit),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef PS2_TX_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

  logic          r_rep_armed;
  logic [RW-1:0] r_rep_cnt;
  logic          w_rep_fire;

  // A new push always wins over a pending repeat so queued events are never delayed.
  assign w_rep_fire  = r_rep_armed && (r_rep_cnt == '0) && w_empty &&
                       (r_holdoff == '0) && !w_push;
  assign w_rest_emit = (w_head.pressed && !w_push) ? ST_REPEAT_WAIT : ST_IDLE;
  assign w_rest_hold = (r_rep_armed && !w_push) ? ST_REPEAT_WAIT : ST_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_armed <= 1'b0;
      r_rep_cnt   <= '0;
    end else if (w_push) begin
      r_rep_armed <= 1'b0;
    end else if (w_emit) begin
      r_rep_armed <= w_head.pressed;
      r_rep_cnt   <= DELAY_LOAD;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= RATE_LOAD;
    end else if (r_rep_armed && (r_rep_cnt != '0)) begin
      r_rep_cnt   <= r_rep_cnt - RW'(1);
    end
  end
`else
  logic w_unused_repeat;

  assign w_unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
  assign w_rest_emit     = ST_IDLE;
  assign w_rest_hold     = ST_IDLE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key     <= '0;
      r_holdoff <= '0;
      r_state   <= ST_IDLE;
    end else if (w_emit) begin
      r_key     <= next_key(r_key, w_head);
      r_holdoff <= HOLD_LOAD;
      r_state   <= (GAP_CYCLES > 1) ? ST_HOLDOFF : w_rest_emit;
`ifdef PS2_TX_REPEAT_EN
    end else if (w_rep_fire) begin
      r_key     <= {~r_key[TOGGLE_BIT], r_key[TOGGLE_BIT-1:0]};
      r_holdoff <= HOLD_LOAD;
      r_state   <= (GAP_CYCLES > 1) ? ST_HOLDOFF : ST_REPEAT_WAIT;
    end else if (w_push && (r_state == ST_REPEAT_WAIT)) begin
      r_state   <= ST_IDLE;
`endif
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - HW'(1);
      if (r_holdoff == HW'(1)) begin
        r_state <= w_empty ? w_rest_hold : ST_HOLDOFF;
      end
    end
  end

endmodule
